// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

  localparam int unsigned ROM_ADDRESS_BITWIDTH_DEFAULT = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;

  localparam logic [LANE_W-1:0] BYTE_LANE_0 = 2'd0;
  localparam logic [LANE_W-1:0] BYTE_LANE_1 = 2'd1;
  localparam logic [LANE_W-1:0] BYTE_LANE_2 = 2'd2;
  localparam logic [LANE_W-1:0] BYTE_LANE_3 = 2'd3;

  typedef enum logic [1:0] {
    LOADER_STATE_RECV_COUNT = 2'd0,
    LOADER_STATE_RECV_WORD  = 2'd1,
    LOADER_STATE_DONE       = 2'd2,
    LOADER_STATE_ERROR      = 2'd3
  } loader_state_t;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid/word are
// combinational so the completing byte is visible in the same cycle.
module byte_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] lanes;

  // Lane counter and partial word; clear drops any partially received word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane  <= '0;
      lanes <= '0;
    end else if (clear) begin
      lane  <= '0;
      lanes <= '0;
    end else if (byte_valid) begin
      case (lane)
        BYTE_LANE_0: lanes[7:0]   <= byte_data;
        BYTE_LANE_1: lanes[15:8]  <= byte_data;
        BYTE_LANE_2: lanes[23:16] <= byte_data;
        default:     lanes[31:24] <= byte_data;
      endcase
      lane <= lane + LANE_W'(1);
    end
  end

  assign word_valid = byte_valid && !clear && (lane == BYTE_LANE_3);
  assign word       = {byte_data, lanes[23:0]};

endmodule

// File: rtl/program_loader.sv
// Receives a word count and instruction words over a byte stream, writes them
// to instruction ROM from address 0, then releases the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ROM_ADDRESS_BITWIDTH = ROM_ADDRESS_BITWIDTH_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_valid,
  input  logic [7:0]                      rx_data,
  input  logic                            reload,
  output logic                            rom_wren,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
  output logic [31:0]                     rom_write_data,
  output logic                            cpu_run,
  output logic                            busy,
  output logic                            error
);

  localparam int unsigned WORD_IDX_W = ROM_ADDRESS_BITWIDTH - 2;
  localparam logic [WORD_W-1:0] CAPACITY = WORD_W'(64'd1 << WORD_IDX_W);

  loader_state_t                   state, state_d;
  logic [WORD_W-1:0]               word_count, word_count_d;
  logic [WORD_W-1:0]               word_index, word_index_d;
  logic                            rom_wren_d;
  logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address_d;
  logic [31:0]                     rom_write_data_d;
  logic                            cpu_run_d, busy_d, error_d;
  logic                            receiving_c;
  logic                            word_valid;
  logic [WORD_W-1:0]               word;

  assign receiving_c = (state == LOADER_STATE_RECV_COUNT) ||
                       (state == LOADER_STATE_RECV_WORD);

  // Bytes outside the receiving states never reach the assembler.
  byte_assembler u_byte_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (reload),
    .byte_valid(rx_valid && receiving_c),
    .byte_data (rx_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LOADER_STATE_RECV_COUNT;
      word_count     <= '0;
      word_index     <= '0;
      rom_wren       <= 1'b0;
      rom_address    <= '0;
      rom_write_data <= '0;
      cpu_run        <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_d;
      word_count     <= word_count_d;
      word_index     <= word_index_d;
      rom_wren       <= rom_wren_d;
      rom_address    <= rom_address_d;
      rom_write_data <= rom_write_data_d;
      cpu_run        <= cpu_run_d;
      busy           <= busy_d;
      error          <= error_d;
    end
  end

  // cpu_run follows the DONE state a cycle late after a data load so the
  // final ROM write lands first; the empty-program path releases immediately.
  always_comb begin
    state_d          = state;
    word_count_d     = word_count;
    word_index_d     = word_index;
    rom_wren_d       = 1'b0;
    rom_address_d    = rom_address;
    rom_write_data_d = rom_write_data;
    cpu_run_d        = (state == LOADER_STATE_DONE);

    if (reload) begin
      state_d      = LOADER_STATE_RECV_COUNT;
      word_count_d = '0;
      word_index_d = '0;
      cpu_run_d    = 1'b0;
    end else begin
      case (state)
        LOADER_STATE_RECV_COUNT: begin
          if (word_valid) begin
            if (word == '0) begin
              state_d   = LOADER_STATE_DONE;
              cpu_run_d = 1'b1;
            end else if (word > CAPACITY) begin
              state_d = LOADER_STATE_ERROR;
            end else begin
              word_count_d = word;
              word_index_d = '0;
              state_d      = LOADER_STATE_RECV_WORD;
            end
          end
        end
        LOADER_STATE_RECV_WORD: begin
          if (word_valid) begin
            rom_wren_d       = 1'b1;
            rom_address_d    = {word_index[WORD_IDX_W-1:0], 2'b00};
            rom_write_data_d = word;
            word_index_d     = word_index + WORD_W'(1);
            if (word_index + WORD_W'(1) == word_count) begin
              state_d = LOADER_STATE_DONE;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d  = (state_d == LOADER_STATE_RECV_COUNT) || (state_d == LOADER_STATE_RECV_WORD);
    error_d = (state_d == LOADER_STATE_ERROR);
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader against a byte-stream model.
module tb_program_loader;

  localparam int unsigned AW  = 12;
  localparam int unsigned CAP = 1 << (AW - 2);

  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          reload = 1'b0;
  logic          rom_wren;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_write_data;
  logic          cpu_run, busy, error;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  wr_t               exp_q[$];
  longint unsigned   m_bytes[$];
  int                m_phase;
  int unsigned       m_n, m_i;
  logic [31:0]       m_rom[CAP];
  bit                m_written[CAP];
  logic [31:0]       s_rom[CAP];

  program_loader #(.ROM_ADDRESS_BITWIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .reload        (reload),
    .rom_wren      (rom_wren),
    .rom_address   (rom_address),
    .rom_write_data(rom_write_data),
    .cpu_run       (cpu_run),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: group bytes in fours; first group is the count, the rest are words.
  task automatic model_restart();
    m_bytes.delete();
    m_phase = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    longint unsigned w;
    if (m_phase >= 2) return;
    m_bytes.push_back(longint'(b));
    if (m_bytes.size() < 4) return;
    w = m_bytes[0] + m_bytes[1] * 256 + m_bytes[2] * 65536 + m_bytes[3] * 16777216;
    m_bytes.delete();
    if (m_phase == 0) begin
      if (w == 0) m_phase = 2;
      else if (w > CAP) m_phase = 3;
      else begin
        m_n = 32'(w);
        m_i = 0;
        m_phase = 1;
      end
    end else begin
      exp_q.push_back('{cyc + 1, AW'(4 * m_i), 32'(w)});
      m_rom[m_i] = 32'(w);
      m_written[m_i] = 1'b1;
      m_i++;
      if (m_i == m_n) m_phase = 2;
    end
  endtask

  // Scoreboard monitor: every ROM write must match the next expected one.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rom_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr 0x%03h data 0x%08h expected none", rom_address, rom_write_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(rom_address), 32'(e.addr));
        check("wr_data", rom_write_data, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
      s_rom[rom_address[AW-1:2]] = rom_write_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    model_byte(b);
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gapmax);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(gapmax, 0)) tick();
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    model_restart();
    tick();
    reload = 1'b0;
  endtask

  task automatic load(input logic [31:0] words[$], input int unsigned gapmax);
    send_word(32'(words.size()), gapmax);
    foreach (words[j]) send_word(words[j], gapmax);
  endtask

  task automatic check_run_after(input int unsigned n);
    @(negedge clk);
    if (n > 0) begin
      check("cpu_run_early", 32'(cpu_run), 32'd0);
      @(negedge clk);
    end
    check("cpu_run_rise", 32'(cpu_run), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("error_done", 32'(error), 32'd0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wren"}, 32'(rom_wren), 32'd0);
    check({tag, "_addr"}, 32'(rom_address), 32'd0);
    check({tag, "_data"}, rom_write_data, 32'd0);
    check({tag, "_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words[$];
    logic [31:0] three[$];
    model_restart();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("busy_after_reset", 32'(busy), 32'd1);
    check("run_after_reset", 32'(cpu_run), 32'd0);
    tick();

    // Two-word program, back to back.
    words = '{32'h00100513, 32'h00200593};
    load(words, 0);
    check_run_after(2);

    // Reload from DONE, then an empty program.
    do_reload();
    @(negedge clk);
    check("run_drop_on_reload", 32'(cpu_run), 32'd0);
    check("busy_on_reload", 32'(busy), 32'd1);
    tick();
    send_word(32'd0, 0);
    check_run_after(0);

    // Oversized count: error, not busy, later bytes ignored.
    do_reload();
    send_word(32'h00000401, 0);
    @(negedge clk);
    check("error_rise", 32'(error), 32'd1);
    check("error_busy", 32'(busy), 32'd0);
    check("error_run", 32'(cpu_run), 32'd0);
    tick();
    for (int k = 0; k < 8; k++) send_byte(8'($urandom()));
    @(negedge clk);
    check("error_sticky", 32'(error), 32'd1);
    tick();

    // Same three words without and with idle gaps.
    three = '{32'($urandom()), 32'($urandom()), 32'($urandom())};
    do_reload();
    load(three, 0);
    check_run_after(3);
    do_reload();
    load(three, 5);
    check_run_after(3);

    // Single-word load, reload, then overwrite word 0.
    do_reload();
    words = '{32'($urandom())};
    load(words, 0);
    check_run_after(1);
    do_reload();
    @(negedge clk);
    check("run_drop_reload2", 32'(cpu_run), 32'd0);
    tick();
    words = '{32'hDEADBEEF};
    load(words, 0);
    check_run_after(1);

    // Asynchronous reset after six bytes, then a fresh load.
    do_reload();
    send_word(32'd2, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    reset = 1'b1;
    model_restart();
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    words = '{32'($urandom()), 32'($urandom())};
    load(words, 0);
    check_run_after(2);

    // Random loads, some interrupted by a reload colliding with a byte.
    for (int it = 0; it < 6; it++) begin
      int unsigned n;
      do_reload();
      if ($urandom_range(1, 0) == 1) begin
        send_word(32'd4, 1);
        for (int k = 0; k < int'($urandom_range(6, 1)); k++) send_byte(8'($urandom()));
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'($urandom());
        model_restart();
        tick();
        reload   = 1'b0;
        rx_valid = 1'b0;
      end
      n = $urandom_range(6, 1);
      words.delete();
      for (int k = 0; k < int'(n); k++) words.push_back(32'($urandom()));
      load(words, $urandom_range(3, 0));
      check_run_after(n);
    end

    repeat (3) tick();
    @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < int'(CAP); k++) begin
      if (m_written[k]) check("rom_contents", s_rom[k], m_rom[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits upstream of the CPU's instruction fetch path. It receives a byte stream from the UART receiver, assembles it into 32-bit little-endian instruction words, and writes them sequentially into instruction ROM starting at byte address 0. It then holds the pipeline's active-low reset released through `cpu_run`. It also owns the decision of when the CPU may start fetching, and supports re-loading without a global reset.

## Interface
Parameters:
- `ROM_ADDRESS_BITWIDTH`, default 12: byte-address width of instruction ROM. Capacity is 2^(ROM_ADDRESS_BITWIDTH-2) words.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `reload`  in  1  one-cycle request to discard the current program and restart loading.
- `rom_wren`  out  1  one-cycle ROM write strobe.
- `rom_address`  out  ROM_ADDRESS_BITWIDTH  byte address of the write; always a multiple of 4.
- `rom_write_data`  out  32  assembled instruction word.
- `cpu_run`  out  1  high means the CPU may run; drives the CPU-side reset_n.
- `busy`  out  1  high while a load is in progress.
- `error`  out  1  high when the requested word count exceeds ROM capacity; sticky.

## Operation
- States:
  - RECV_COUNT: collect 4 bytes forming word count N, least significant byte first.
  - RECV_WORD: collect 4 bytes per instruction word.
  - DONE: loading complete, CPU running.
  - ERROR: loading aborted.
- Reset state is RECV_COUNT. Reset values: all outputs 0, byte counter 0, word counter 0, assembly register 0.
- Byte assembly: the 2-bit byte counter selects the lane; byte k goes to bits [8k+7:8k]. The counter wraps 3→0 on the fourth byte, completing the word.
- RECV_COUNT, on word completion:
  - N == 0 → DONE.
  - N > capacity → ERROR.
  - Otherwise latch N and go to RECV_WORD.
- RECV_WORD, on word completion:
  - Issue a write for word index i: address 4·i, data = the assembled word.
  - Increment i.
  - When i reaches N after this write, go to DONE.
- Bytes arriving in DONE or ERROR are ignored; no writes occur.
- `busy` = state ∈ {RECV_COUNT, RECV_WORD} and not in reset. `error` = state == ERROR. `cpu_run` = state == DONE.
- `reload` in any state:
  - Go to RECV_COUNT, clear the counters, drop `cpu_run` and `error`.
  - Has priority over a simultaneous `rx_valid`; that byte is dropped.
  - A write already scheduled for the next cycle still occurs.
- Word-count arithmetic is 32-bit unsigned. The comparison against capacity uses the full 32 bits, with no truncation.

## Timing
- Accepts one byte per cycle with no backpressure. Back-to-back `rx_valid` is legal in every receiving state.
- `rom_wren`, `rom_address` and `rom_write_data` are registered. They assert exactly 1 cycle after the `rx_valid` carrying byte 3 of a word, for exactly 1 cycle.
- The write of word i+1 never coincides with the write of word i.
- `cpu_run` rises 1 cycle after the final `rom_wren` cycle, which is 2 cycles after the last byte. The ROM is therefore fully written before the CPU leaves reset.
- For N == 0, `cpu_run` rises 1 cycle after the fourth count byte.
- `error` rises 1 cycle after the fourth count byte.
- `reset` mid-load takes effect immediately and asynchronously: all outputs go to 0. Partially written ROM contents are not cleared.

## Structure
- Shared package holds:
  - state encoding: LOADER_STATE_RECV_COUNT / RECV_WORD / DONE / ERROR;
  - byte-lane constants;
  - the default value of ROM_ADDRESS_BITWIDTH, shared with the ROM and PC.
- Sub-module `byte_assembler`:
  - contents: 2-bit counter plus a 32-bit shift/lane register;
  - outputs: `word_valid` pulse and `word`;
  - inputs: `clear` (driven by `reload`).
- The FSM, word counter and write register stay in `program_loader`.

## Test plan
- N=2, bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 sent back-to-back:
  - writes 0x00100513 at address 0x000 and 0x00200593 at address 0x004;
  - `cpu_run` rises 2 cycles after the last byte.
- Count bytes 00 00 00 00 → no `rom_wren`; `cpu_run`=1 one cycle after the fourth byte.
- ROM_ADDRESS_BITWIDTH=12, count 0x00000401 (capacity 1024) → `error`=1, `busy`=0, no writes, and later bytes are ignored.
- Bytes spaced with random gaps of 0–5 idle cycles, N=3 → the same three words at 0, 4, 8 as in the gap-free run.
- Load N=1, then `reload` in DONE, then load N=1 with word 0xDEADBEEF:
  - `cpu_run` drops the cycle after `reload`;
  - address 0 is rewritten with 0xDEADBEEF;
  - `cpu_run` rises again.
- Assert `reset` after 6 bytes of a load → all outputs 0 immediately; a fresh full load afterwards succeeds.
